// File: rtl/tdc_interval_tile.sv
// -----------------------------------------------------------------------------
// tdc_interval_tile
//
// Counter-based time-to-digital converter micro-tile. It measures the number of
// clk cycles between a start edge and a stop edge on ui_in and exposes the
// result, the live counter and a status byte one byte at a time on uo_out.
//
// The tile lives inside a micro-tile container. When the container deselects
// it, clk is held low and ui_in is forced to 0x00, so every register simply
// freezes. No special handling is needed here.
//
// Parameters
//   CNT_W        interval counter / result width (8..16). The high result byte
//                is zero-extended when CNT_W < 16.
//   SYNC_STAGES  number of synchroniser flops on the start and stop pins (>= 2).
//
// Ports
//   clk     clock (gated low by the container when the tile is deselected)
//   rst     synchronous, active-high reset
//   ui_in   [0] start pin, [1] stop pin, [2] arm, [3] clear (level),
//           [4] pol (0 = rising edges, 1 = falling edges), [6:5] out_sel,
//           [7] unused
//   uo_out  registered readback byte selected by out_sel:
//             00 result[7:0]
//             01 result[15:8] (zero when CNT_W <= 8)
//             10 {state[1:0], ovf, 1'b0, meas_cnt[3:0]}
//             11 counter[7:0] (live)
// -----------------------------------------------------------------------------
module tdc_interval_tile #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out
);

    // The status byte exposes these codes directly, so the encoding is fixed.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        COUNT = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        SEL_RES_LO = 2'b00,
        SEL_RES_HI = 2'b01,
        SEL_STATUS = 2'b10,
        SEL_COUNT  = 2'b11
    } sel_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Input field decode
    // -------------------------------------------------------------------------
    logic start_pin;
    logic stop_pin;
    logic arm_pin;
    logic clear;
    logic pol;
    sel_t out_sel;
    logic unused_ui7;

    assign start_pin  = ui_in[0];
    assign stop_pin   = ui_in[1];
    assign arm_pin    = ui_in[2];
    assign clear      = ui_in[3];
    assign pol        = ui_in[4];
    assign out_sel    = sel_t'(ui_in[6:5]);
    assign unused_ui7 = ui_in[7];

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                 state_q,      state_d;
    logic [SYNC_STAGES-1:0] start_sync_q, start_sync_d;
    logic [SYNC_STAGES-1:0] stop_sync_q,  stop_sync_d;
    logic                   start_dly_q,  start_dly_d;
    logic                   stop_dly_q,   stop_dly_d;
    logic                   arm_dly_q,    arm_dly_d;
    logic [CNT_W-1:0]       counter_q,    counter_d;
    logic [CNT_W-1:0]       result_q,     result_d;
    logic                   ovf_q,        ovf_d;
    logic [3:0]             meas_q,       meas_d;
    logic [7:0]             uo_out_q,     uo_out_d;

    // -------------------------------------------------------------------------
    // Synchronisers and edge detection
    //
    // Start and stop travel through identical chains (SYNC_STAGES flops plus
    // one delay flop), so both events lag their pins by the same number of
    // cycles and the measured interval equals the pin-to-pin interval.
    // -------------------------------------------------------------------------
    logic start_now;
    logic stop_now;
    logic start_evt;
    logic stop_evt;
    logic arm_evt;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        start_sync_d = {start_sync_q[SYNC_STAGES-2:0], start_pin};
        stop_sync_d  = {stop_sync_q[SYNC_STAGES-2:0],  stop_pin};
        start_dly_d  = start_sync_q[SYNC_STAGES-1];
        stop_dly_d   = stop_sync_q[SYNC_STAGES-1];
        arm_dly_d    = arm_pin;
    end

    assign start_now = start_sync_q[SYNC_STAGES-1];
    assign stop_now  = stop_sync_q[SYNC_STAGES-1];

    // pol selects which transition of the synchronised pin counts as the event.
    assign start_evt = pol ? (start_dly_q & ~start_now) : (~start_dly_q & start_now);
    assign stop_evt  = pol ? (stop_dly_q  & ~stop_now)  : (~stop_dly_q  & stop_now);

    // arm is a container-driven control, so a plain edge detect is enough.
    assign arm_evt   = arm_pin & ~arm_dly_q;

    // -------------------------------------------------------------------------
    // Saturating increment shared by the counter and the result capture.
    // -------------------------------------------------------------------------
    logic             cnt_at_max;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_at_max = (counter_q == CNT_MAX);
    assign cnt_inc    = cnt_at_max ? CNT_MAX : (counter_q + CNT_ONE);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic. clear wins over every other event.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (arm_evt)   state_d = ARMED;
                // A stop arriving in the same cycle as start is dropped.
                ARMED:   if (start_evt) state_d = COUNT;
                COUNT:   if (stop_evt)  state_d = DONE;
                DONE:    if (arm_evt)   state_d = ARMED;
                default:                state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (measurement datapath)
    // -------------------------------------------------------------------------
    always_comb begin
        counter_d = counter_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        meas_d    = meas_q;

        if (clear) begin
            // Aborts any measurement in flight; nothing partial is kept.
            counter_d = '0;
            result_d  = '0;
            ovf_d     = 1'b0;
            meas_d    = 4'd0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (start_evt) begin
                        counter_d = '0;
                        ovf_d     = 1'b0;
                    end
                end
                COUNT: begin
                    // The counter holds the cycles elapsed since the start
                    // event, so the stop cycle itself adds one more.
                    if (stop_evt) begin
                        result_d = cnt_inc;
                        meas_d   = meas_q + 4'd1;
                    end else begin
                        counter_d = cnt_inc;
                    end
                    // Clamping in either branch flags overflow; the wait for
                    // stop continues after the counter has saturated.
                    if (cnt_at_max) begin
                        ovf_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Readback mux. It is registered, so uo_out follows out_sel and the state
    // one cycle later.
    // -------------------------------------------------------------------------
    logic [15:0] result_ext;

    assign result_ext = 16'(result_q);

    always_comb begin
        uo_out_d = 8'h00;
        case (out_sel)
            SEL_RES_LO: uo_out_d = result_ext[7:0];
            SEL_RES_HI: uo_out_d = result_ext[15:8];
            SEL_STATUS: uo_out_d = {state_q, ovf_q, 1'b0, meas_q};
            SEL_COUNT:  uo_out_d = counter_q[7:0];
            default:    uo_out_d = 8'h00;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath, synchroniser and readback registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            start_sync_q <= '0;
            stop_sync_q  <= '0;
            start_dly_q  <= 1'b0;
            stop_dly_q   <= 1'b0;
            arm_dly_q    <= 1'b0;
            counter_q    <= '0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            meas_q       <= 4'd0;
            uo_out_q     <= 8'h00;
        end else begin
            start_sync_q <= start_sync_d;
            stop_sync_q  <= stop_sync_d;
            start_dly_q  <= start_dly_d;
            stop_dly_q   <= stop_dly_d;
            arm_dly_q    <= arm_dly_d;
            counter_q    <= counter_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            meas_q       <= meas_d;
            uo_out_q     <= uo_out_d;
        end
    end

    assign uo_out = uo_out_q;

endmodule

// File: tb/tb_tdc_interval_tile.sv
// -----------------------------------------------------------------------------
// tb_tdc_interval_tile
//
// Drives a 16-bit and an 8-bit instance of tdc_interval_tile from the same
// inputs. A timestamp-based reference model predicts uo_out of both every
// cycle. A table of measurements with hand-derived expected bytes and a few
// directed sequences cover the corner cases.
// -----------------------------------------------------------------------------
module tb_tdc_interval_tile;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uo16;
    logic [7:0] uo8;

    always #5 clk = ~clk;

    tdc_interval_tile #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut16 (
        .clk    (clk),
        .rst    (rst),
        .ui_in  (ui_in),
        .uo_out (uo16)
    );

    tdc_interval_tile #(.CNT_W(8), .SYNC_STAGES(SYNC)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .ui_in  (ui_in),
        .uo_out (uo8)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model. Index 0 models CNT_W=16, index 1 models CNT_W=8.
    // A measurement is a start timestamp; counter, result and overflow are
    // derived from the elapsed number of cycles.
    // -------------------------------------------------------------------------
    int          cyc = 0;
    bit          st_hist[$];      // pin samples, newest first
    bit          sp_hist[$];
    bit          arm_prev;
    int          m_phase  [2];    // 0 idle, 1 armed, 2 counting, 3 done
    int unsigned m_res    [2];
    int unsigned m_cnt    [2];
    bit          m_ovf    [2];
    int          m_meas   [2];
    int          m_tstart [2];
    int unsigned m_max    [2] = '{65535, 255};
    logic [7:0]  exp_uo   [2];

    task automatic model_step(input bit r, input logic [7:0] u);
        bit          st_evt;
        bit          sp_evt;
        bit          arm_evt;
        int unsigned n;
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0;
                m_res[i]   = 0;
                m_cnt[i]   = 0;
                m_ovf[i]   = 1'b0;
                m_meas[i]  = 0;
                exp_uo[i]  = 8'h00;
            end
            st_hist = {};
            sp_hist = {};
            for (int k = 0; k <= SYNC; k++) begin
                st_hist.push_back(1'b0);
                sp_hist.push_back(1'b0);
            end
            arm_prev = 1'b0;
            cyc++;
            return;
        end
        // An event is seen SYNC+1 edges after the pin sample that caused it.
        if (u[4]) begin
            st_evt = st_hist[SYNC] && !st_hist[SYNC-1];
            sp_evt = sp_hist[SYNC] && !sp_hist[SYNC-1];
        end else begin
            st_evt = !st_hist[SYNC] && st_hist[SYNC-1];
            sp_evt = !sp_hist[SYNC] && sp_hist[SYNC-1];
        end
        arm_evt = u[2] && !arm_prev;

        for (int i = 0; i < 2; i++) begin
            case (u[6:5])
                2'b00:   exp_uo[i] = 8'(m_res[i]);
                2'b01:   exp_uo[i] = 8'(m_res[i] >> 8);
                2'b10:   exp_uo[i] = 8'(m_phase[i] * 64 + (m_ovf[i] ? 32 : 0) + m_meas[i]);
                default: exp_uo[i] = 8'(m_cnt[i]);
            endcase

            if (u[3]) begin
                m_phase[i] = 0;
                m_res[i]   = 0;
                m_cnt[i]   = 0;
                m_ovf[i]   = 1'b0;
                m_meas[i]  = 0;
            end else begin
                case (m_phase[i])
                    0: if (arm_evt) m_phase[i] = 1;
                    1: if (st_evt) begin
                        m_phase[i]  = 2;
                        m_tstart[i] = cyc;
                        m_cnt[i]    = 0;
                        m_ovf[i]    = 1'b0;
                    end
                    2: begin
                        n = cyc - m_tstart[i];
                        if (n > m_max[i]) m_ovf[i] = 1'b1;
                        if (sp_evt) begin
                            m_res[i]   = (n > m_max[i]) ? m_max[i] : n;
                            m_meas[i]  = (m_meas[i] + 1) % 16;
                            m_phase[i] = 3;
                        end else begin
                            m_cnt[i] = (n > m_max[i]) ? m_max[i] : n;
                        end
                    end
                    default: if (arm_evt) m_phase[i] = 1;
                endcase
            end
        end

        st_hist.push_front(u[0]);
        void'(st_hist.pop_back());
        sp_hist.push_front(u[1]);
        void'(sp_hist.pop_back());
        arm_prev = u[2];
        cyc++;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus helpers. Inputs change after the falling edge; outputs are
    // compared after the next falling edge, half a cycle from the active edge.
    // -------------------------------------------------------------------------
    logic [7:0] u_cur = 8'h00;

    task automatic tick(input bit r, input logic [7:0] u);
        rst   = r;
        ui_in = u;
        model_step(r, u);
        @(posedge clk);
        @(negedge clk);
        check("model16", uo16, exp_uo[0]);
        check("model8",  uo8,  exp_uo[1]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, u_cur);
    endtask

    task automatic read(input string name, input logic [1:0] sel,
                        input logic [7:0] e16, input logic [7:0] e8);
        u_cur[6:5] = sel;
        tick(1'b0, u_cur);
        check({name, "_16"}, uo16, e16);
        check({name, "_8"},  uo8,  e8);
    endtask

    task automatic do_reset(input logic [7:0] u);
        u_cur = u;
        tick(1'b1, u_cur);
        tick(1'b1, u_cur);
        idle(4);
    endtask

    task automatic arm_pulse();
        u_cur[2] = 1'b1;
        tick(1'b0, u_cur);
        u_cur[2] = 1'b0;
        tick(1'b0, u_cur);
    endtask

    // -------------------------------------------------------------------------
    // Measurement table
    // -------------------------------------------------------------------------
    typedef struct {
        string      name;
        bit         pol;
        bit         stray;
        int         interval;
        logic [7:0] e16_lo, e16_hi, e16_st, e16_cnt;
        logic [7:0] e8_lo,  e8_hi,  e8_st,  e8_cnt;
    } row_t;

    row_t rows[6];

    initial begin
        logic act;
        bit   r;

        rows[0] = '{"rise37",   1'b0, 1'b0, 37,  8'h25, 8'h00, 8'hC1, 8'h24, 8'h25, 8'h00, 8'hC1, 8'h24};
        rows[1] = '{"stray300", 1'b0, 1'b1, 300, 8'h2C, 8'h01, 8'hC1, 8'h2B, 8'hFF, 8'h00, 8'hE1, 8'hFF};
        rows[2] = '{"fall5",    1'b1, 1'b0, 5,   8'h05, 8'h00, 8'hC1, 8'h04, 8'h05, 8'h00, 8'hC1, 8'h04};
        rows[3] = '{"rise1",    1'b0, 1'b0, 1,   8'h01, 8'h00, 8'hC1, 8'h00, 8'h01, 8'h00, 8'hC1, 8'h00};
        rows[4] = '{"rise255",  1'b0, 1'b0, 255, 8'hFF, 8'h00, 8'hC1, 8'hFE, 8'hFF, 8'h00, 8'hC1, 8'hFE};
        rows[5] = '{"rise256",  1'b0, 1'b0, 256, 8'h00, 8'h01, 8'hC1, 8'hFF, 8'hFF, 8'h00, 8'hE1, 8'hFF};

        rst   = 1'b1;
        ui_in = 8'h00;

        // Reset state on every readback lane.
        do_reset(8'h00);
        for (int s = 0; s < 4; s++) begin
            read($sformatf("reset_sel%0d", s), 2'(s), 8'h00, 8'h00);
        end

        // Table-driven measurements, each from a fresh reset.
        for (int i = 0; i < 6; i++) begin
            do_reset(rows[i].pol ? 8'h13 : 8'h00);
            arm_pulse();
            act = ~rows[i].pol;
            if (rows[i].stray) begin
                u_cur[1] = act;
                idle(4);
                u_cur[1] = ~act;
                idle(4);
            end
            u_cur[0] = act;
            idle(rows[i].interval);
            u_cur[1] = act;
            idle(6);
            read({rows[i].name, "_lo"},  2'b00, rows[i].e16_lo,  rows[i].e8_lo);
            read({rows[i].name, "_hi"},  2'b01, rows[i].e16_hi,  rows[i].e8_hi);
            read({rows[i].name, "_st"},  2'b10, rows[i].e16_st,  rows[i].e8_st);
            read({rows[i].name, "_cnt"}, 2'b11, rows[i].e16_cnt, rows[i].e8_cnt);
        end

        // Falling polarity: rising edges ignored, simultaneous start+stop in
        // ARMED starts counting and drops the stop.
        do_reset(8'h10);
        arm_pulse();
        u_cur[1:0] = 2'b11;
        idle(5);
        read("pol_rise_ignored", 2'b10, 8'h40, 8'h40);
        u_cur[1:0] = 2'b00;
        idle(5);
        read("pol_same_cycle", 2'b10, 8'h80, 8'h80);
        u_cur[1] = 1'b1;
        idle(4);
        read("pol_stop_rise", 2'b10, 8'h80, 8'h80);
        u_cur[1] = 1'b0;
        idle(5);
        read("pol_stop_fall", 2'b10, 8'hC1, 8'hC1);

        // Clear mid-COUNT after the 8-bit counter has saturated.
        do_reset(8'h00);
        arm_pulse();
        u_cur[0] = 1'b1;
        idle(300);
        read("count_ovf", 2'b10, 8'h80, 8'hA0);
        u_cur[3] = 1'b1;
        tick(1'b0, u_cur);
        u_cur[3] = 1'b0;
        read("clear_st",  2'b10, 8'h00, 8'h00);
        read("clear_res", 2'b00, 8'h00, 8'h00);
        read("clear_cnt", 2'b11, 8'h00, 8'h00);

        // Sixteen measurements wrap meas_cnt; re-arm from DONE each time.
        do_reset(8'h00);
        for (int m = 1; m <= 16; m++) begin
            arm_pulse();
            u_cur[0] = 1'b1;
            idle(3);
            u_cur[1] = 1'b1;
            idle(5);
            u_cur[1:0] = 2'b00;
            idle(4);
            read($sformatf("meas%0d", m), 2'b10, 8'hC0 | 8'(m % 16), 8'hC0 | 8'(m % 16));
        end

        // Reset mid-COUNT clears every lane.
        arm_pulse();
        u_cur[0] = 1'b1;
        idle(10);
        tick(1'b1, u_cur);
        for (int s = 0; s < 4; s++) begin
            read($sformatf("rst_mid_sel%0d", s), 2'(s), 8'h00, 8'h00);
        end

        // Randomised traffic against the model.
        do_reset(8'h00);
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 7) == 0) u_cur[0] = ~u_cur[0];
            if ($urandom_range(0, 9) == 0) u_cur[1] = ~u_cur[1];
            u_cur[2]   = ($urandom_range(0, 11) == 0);
            u_cur[3]   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 499) == 0) u_cur[4] = ~u_cur[4];
            u_cur[6:5] = 2'($urandom_range(0, 3));
            u_cur[7]   = 1'($urandom);
            tick(r, u_cur);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
